// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the SRAM-to-AXI3 bridge:
//   - AXI transaction IDs used to steer read responses back to a requester
//   - fixed AXI3 attribute tie-offs (single-beat INCR, normal, non-cacheable)
//   - write-channel sequencing state encoding
//   - helper turning an SRAM size code into an AXI size field
// ---------------------------------------------------------------------------
package axi_pkg;

  // Read/write transaction IDs
  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;

  // Fixed AXI3 attributes: every transfer is a single beat
  localparam logic [3:0] AXI_LEN_SINGLE  = 4'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE  = 4'd0;
  localparam logic [2:0] AXI_PROT_NONE   = 3'd0;

  // Fetches are always full words; the fetch port's size input is ignored
  localparam logic [2:0] INST_FETCH_SIZE = 3'd2;

  // Write sequencing: both AW and W are offered together, and whichever
  // finishes first leaves the state that still waits on the other one.
  typedef enum logic [2:0] {
    WR_IDLE,
    WR_BOTH,     // awvalid and wvalid both asserted
    WR_AW_ONLY,  // W done, AW still waiting
    WR_W_ONLY,   // AW done, W still waiting
    WR_B_WAIT    // both done, waiting for the write response
  } wr_state_e;

  // SRAM size (bytes = 1 << size) maps straight onto AXI size
  function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage

// File: rtl/axi_write_fsm.sv
// ---------------------------------------------------------------------------
// axi_write_fsm
// Sequences one AXI3 single-beat write through AW, W and B.
// A write is captured when start_i is pulsed in IDLE; its payload is held
// stable on the AW/W outputs until each channel handshakes.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   start_i               accept a new write (only honoured in IDLE)
//   addr_i/size_i         write address / SRAM size code
//   wdata_i/wstrb_i       write data / byte enables
//   idle_o                FSM is idle and can accept a write
//   done_o                write response received (one-cycle pulse)
//   awvalid_o/awready_i   AW handshake; awaddr_o/awsize_o payload
//   wvalid_o/wready_i     W handshake;  wdata_o/wstrb_o payload
//   bvalid_i              B channel valid (bready is tied high upstream)
// ---------------------------------------------------------------------------
module axi_write_fsm
  import axi_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        idle_o,
  output logic        done_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] awaddr_o,
  output logic [2:0]  awsize_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  input  logic        bvalid_i
);

  wr_state_e   state_q, state_d;
  logic [31:0] awaddr_q;
  logic [2:0]  awsize_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= WR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload is captured once at accept and held until the next accept
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      awaddr_q <= '0;
      awsize_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (start_i && state_q == WR_IDLE) begin
      awaddr_q <= addr_i;
      awsize_q <= axi_size(size_i);
      wdata_q  <= wdata_i;
      wstrb_q  <= wstrb_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    idle_o    = 1'b0;
    done_o    = 1'b0;
    awvalid_o = 1'b0;
    wvalid_o  = 1'b0;
    case (state_q)
      WR_IDLE: begin
        idle_o = 1'b1;
        if (start_i) state_d = WR_BOTH;
      end
      WR_BOTH: begin
        awvalid_o = 1'b1;
        wvalid_o  = 1'b1;
        if (awready_i && wready_i) state_d = WR_B_WAIT;
        else if (awready_i)        state_d = WR_W_ONLY;
        else if (wready_i)         state_d = WR_AW_ONLY;
      end
      WR_AW_ONLY: begin
        awvalid_o = 1'b1;
        if (awready_i) state_d = WR_B_WAIT;
      end
      WR_W_ONLY: begin
        wvalid_o = 1'b1;
        if (wready_i) state_d = WR_B_WAIT;
      end
      WR_B_WAIT: begin
        if (bvalid_i) begin
          done_o  = 1'b1;
          state_d = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  assign awaddr_o = awaddr_q;
  assign awsize_o = awsize_q;
  assign wdata_o  = wdata_q;
  assign wstrb_o  = wstrb_q;

endmodule

// File: rtl/sram_axi_bridge.sv
// ---------------------------------------------------------------------------
// sram_axi_bridge
// Merges the fetch (inst_sram_*) and data (data_sram_*) SRAM-style ports
// onto one AXI3 master. Reads share a single AR slot, data reads winning
// over fetches, and return by ID. Data writes go through axi_write_fsm.
// Data reads and data writes interlock so that a read never overtakes a
// write still in flight and vice versa.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   inst_sram_*                fetch port (read only; wr/size/wstrb/wdata ignored)
//   data_sram_*                data port (read or write)
//   ar*, r*                    AXI3 read address / read data channels
//   aw*, w*, b*                AXI3 write address / data / response channels
// ---------------------------------------------------------------------------
module sram_axi_bridge
  import axi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data port
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic        bvalid,
  output logic        bready
);

  // AR slot
  logic        ar_valid_q, ar_valid_d;
  logic [3:0]  ar_id_q, ar_id_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [2:0]  ar_size_q, ar_size_d;

  // One outstanding read per requester
  logic inst_pend_q, inst_pend_d;
  logic data_pend_q, data_pend_d;

  logic wr_idle;
  logic wr_done;
  logic data_rd_acc;
  logic inst_rd_acc;
  logic data_wr_acc;
  logic inst_r_hit;
  logic data_r_hit;

  // The fetch port is read-only; its write-side inputs have no effect
  logic unused_inst_sram;
  assign unused_inst_sram = ^{inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata};

  // Accepts look at the slot as registered, so a slot freed by this
  // cycle's AR handshake is only reusable from the next cycle.
  assign data_rd_acc = !reset && data_sram_req && !data_sram_wr && !ar_valid_q
                       && !data_pend_q && wr_idle;
  assign inst_rd_acc = !reset && inst_sram_req && !ar_valid_q && !inst_pend_q
                       && !data_rd_acc;
  assign data_wr_acc = !reset && data_sram_req && data_sram_wr && wr_idle
                       && !data_pend_q;

  // R beats with a foreign ID or no matching outstanding read are dropped
  assign inst_r_hit = !reset && rvalid && (rid == INST_ID) && inst_pend_q;
  assign data_r_hit = !reset && rvalid && (rid == DATA_ID) && data_pend_q;

  always_comb begin
    ar_valid_d = ar_valid_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_size_d  = ar_size_q;
    if (ar_valid_q && arready) ar_valid_d = 1'b0;
    if (data_rd_acc) begin
      ar_valid_d = 1'b1;
      ar_id_d    = DATA_ID;
      ar_addr_d  = data_sram_addr;
      ar_size_d  = axi_size(data_sram_size);
    end else if (inst_rd_acc) begin
      ar_valid_d = 1'b1;
      ar_id_d    = INST_ID;
      ar_addr_d  = inst_sram_addr;
      ar_size_d  = INST_FETCH_SIZE;
    end
  end

  // Accept requires the flag clear, so clear-and-set never collide
  always_comb begin
    inst_pend_d = (inst_pend_q && !inst_r_hit) || inst_rd_acc;
    data_pend_d = (data_pend_q && !data_r_hit) || data_rd_acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_valid_q  <= 1'b0;
      ar_id_q     <= '0;
      ar_addr_q   <= '0;
      ar_size_q   <= '0;
      inst_pend_q <= 1'b0;
      data_pend_q <= 1'b0;
    end else begin
      ar_valid_q  <= ar_valid_d;
      ar_id_q     <= ar_id_d;
      ar_addr_q   <= ar_addr_d;
      ar_size_q   <= ar_size_d;
      inst_pend_q <= inst_pend_d;
      data_pend_q <= data_pend_d;
    end
  end

  axi_write_fsm u_write_fsm (
    .clk_i     (clk),
    .reset_i   (reset),
    .start_i   (data_wr_acc),
    .addr_i    (data_sram_addr),
    .size_i    (data_sram_size),
    .wdata_i   (data_sram_wdata),
    .wstrb_i   (data_sram_wstrb),
    .idle_o    (wr_idle),
    .done_o    (wr_done),
    .awvalid_o (awvalid),
    .awready_i (awready),
    .awaddr_o  (awaddr),
    .awsize_o  (awsize),
    .wvalid_o  (wvalid),
    .wready_i  (wready),
    .wdata_o   (wdata),
    .wstrb_o   (wstrb),
    .bvalid_i  (bvalid)
  );

  // SRAM-side handshakes
  assign inst_sram_addr_ok = inst_rd_acc;
  assign data_sram_addr_ok = data_rd_acc || data_wr_acc;
  assign inst_sram_data_ok = inst_r_hit;
  assign data_sram_data_ok = data_r_hit || (!reset && wr_done);
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  // AR channel
  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arsize  = ar_size_q;
  assign arvalid = ar_valid_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NORMAL;
  assign arcache = AXI_CACHE_NONE;
  assign arprot  = AXI_PROT_NONE;

  // Responses are always accepted
  assign rready = 1'b1;
  assign bready = 1'b1;

  // AW/W fixed attributes
  assign awid    = DATA_ID;
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = AXI_LOCK_NORMAL;
  assign awcache = AXI_CACHE_NONE;
  assign awprot  = AXI_PROT_NONE;
  assign wid     = DATA_ID;
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// ---------------------------------------------------------------------------
// tb_sram_axi_bridge
// Directed stimulus drives the SRAM ports and plays the AXI slave by hand.
// Expected responses are queued when a request is issued; a monitor on the
// falling edge pops and compares each data_ok the bridge produces.
// ---------------------------------------------------------------------------
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [3:0]  awid, awlen, awcache;
  logic [31:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready;
  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready;

  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_wr;
    logic [31:0] rdata;
  } exp_t;

  logic [31:0] inst_q[$];
  exp_t        data_q[$];
  logic [31:0] inst_e;
  exp_t        data_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_data(input bit is_wr, input logic [31:0] val);
    exp_t e;
    e.is_wr = is_wr;
    e.rdata = val;
    data_q.push_back(e);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (inst_sram_data_ok === 1'b1) begin
      if (inst_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL inst_unexpected_data_ok: got data_ok with rdata 0x%08h, expected none", inst_sram_rdata);
      end else begin
        inst_e = inst_q.pop_front();
        chk("inst_rdata", inst_sram_rdata, inst_e);
        $display("inst read response rdata=0x%08h", inst_sram_rdata);
      end
    end
    if (data_sram_data_ok === 1'b1) begin
      if (data_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data_unexpected_data_ok: got data_ok with rdata 0x%08h, expected none", data_sram_rdata);
      end else begin
        data_e = data_q.pop_front();
        if (data_e.is_wr) begin
          chk("data_wr_done_on_bvalid", {31'b0, bvalid}, 32'd1);
          $display("data write response");
        end else begin
          chk("data_rdata", data_sram_rdata, data_e.rdata);
          $display("data read response rdata=0x%08h", data_sram_rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;

    // ---- reset state ----
    tick(); tick();
    inst_sram_req = 1; inst_sram_addr = 32'h1C000000;
    #1;
    chk("rst_inst_addr_ok", {31'b0, inst_sram_addr_ok}, 32'd0);
    tick();
    reset = 0; inst_sram_req = 0;
    #1;
    chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
    chk("rst_awvalid", {31'b0, awvalid}, 32'd0);
    chk("rst_wvalid", {31'b0, wvalid}, 32'd0);
    chk("rst_rready", {31'b0, rready}, 32'd1);
    chk("rst_bready", {31'b0, bready}, 32'd1);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_wstrb", {28'b0, wstrb}, 32'd0);
    chk("tieoff_arburst", {30'b0, arburst}, 32'd1);
    chk("tieoff_wlast", {31'b0, wlast}, 32'd1);
    chk("tieoff_awid", {28'b0, awid}, 32'd1);

    // ---- fetch read alone ----
    tick();
    inst_sram_req = 1; inst_sram_addr = 32'h1C000000; arready = 1;
    #1;
    chk("f1_inst_addr_ok_c0", {31'b0, inst_sram_addr_ok}, 32'd1);
    chk("f1_arvalid_c0", {31'b0, arvalid}, 32'd0);
    inst_q.push_back(32'h02800C0C);
    tick();
    inst_sram_req = 0;
    #1;
    chk("f1_arvalid_c1", {31'b0, arvalid}, 32'd1);
    chk("f1_araddr", araddr, 32'h1C000000);
    chk("f1_arid", {28'b0, arid}, 32'd0);
    tick();
    #1;
    chk("f1_arvalid_c2", {31'b0, arvalid}, 32'd0);
    chk("f1_inst_data_ok_c2", {31'b0, inst_sram_data_ok}, 32'd0);
    tick();
    rvalid = 1; rid = 4'd0; rdata = 32'h02800C0C;
    #1;
    chk("f1_inst_data_ok_c3", {31'b0, inst_sram_data_ok}, 32'd1);
    tick();
    rvalid = 0; arready = 0;

    // ---- simultaneous fetch and data reads ----
    inst_sram_req = 1; inst_sram_addr = 32'h1C000040;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1C001000; data_sram_size = 2'd2;
    #1;
    chk("f2_data_addr_ok", {31'b0, data_sram_addr_ok}, 32'd1);
    chk("f2_inst_addr_ok_c0", {31'b0, inst_sram_addr_ok}, 32'd0);
    push_data(1'b0, 32'h11111111);
    tick();
    data_sram_req = 0; arready = 1;
    #1;
    chk("f2_arid_data", {28'b0, arid}, 32'd1);
    chk("f2_araddr_data", araddr, 32'h1C001000);
    chk("f2_arsize_data", {29'b0, arsize}, 32'd2);
    chk("f2_inst_addr_ok_c1", {31'b0, inst_sram_addr_ok}, 32'd0);
    tick();
    #1;
    chk("f2_inst_addr_ok_c2", {31'b0, inst_sram_addr_ok}, 32'd1);
    inst_q.push_back(32'h22222222);
    tick();
    inst_sram_req = 0;
    #1;
    chk("f2_arvalid_inst", {31'b0, arvalid}, 32'd1);
    chk("f2_arid_inst", {28'b0, arid}, 32'd0);
    chk("f2_araddr_inst", araddr, 32'h1C000040);
    tick();
    arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h11111111;
    #1;
    chk("f2_data_ok_rid1", {31'b0, data_sram_data_ok}, 32'd1);
    chk("f2_inst_ok_rid1", {31'b0, inst_sram_data_ok}, 32'd0);
    tick();
    rid = 4'd0; rdata = 32'h22222222;
    #1;
    chk("f2_inst_ok_rid0", {31'b0, inst_sram_data_ok}, 32'd1);
    chk("f2_data_ok_rid0", {31'b0, data_sram_data_ok}, 32'd0);
    tick();
    rvalid = 0;

    // ---- data write, AW first then W three cycles later ----
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1C008000;
    data_sram_size = 2'd1; data_sram_wstrb = 4'b0011; data_sram_wdata = 32'hA5A5BEEF;
    #1;
    chk("w1_addr_ok", {31'b0, data_sram_addr_ok}, 32'd1);
    chk("w1_awvalid_c0", {31'b0, awvalid}, 32'd0);
    push_data(1'b1, 32'h0);
    tick();
    data_sram_req = 0; data_sram_wr = 0; awready = 1;
    #1;
    chk("w1_awvalid_c1", {31'b0, awvalid}, 32'd1);
    chk("w1_wvalid_c1", {31'b0, wvalid}, 32'd1);
    chk("w1_awaddr", awaddr, 32'h1C008000);
    chk("w1_awsize", {29'b0, awsize}, 32'd1);
    chk("w1_wdata", wdata, 32'hA5A5BEEF);
    chk("w1_wstrb", {28'b0, wstrb}, 32'b0011);
    tick();
    awready = 0;
    #1;
    chk("w1_awvalid_c2", {31'b0, awvalid}, 32'd0);
    chk("w1_wvalid_c2", {31'b0, wvalid}, 32'd1);
    tick();
    #1;
    chk("w1_wvalid_c3", {31'b0, wvalid}, 32'd1);
    chk("w1_awvalid_c3", {31'b0, awvalid}, 32'd0);
    tick();
    wready = 1;
    #1;
    chk("w1_wvalid_c4", {31'b0, wvalid}, 32'd1);
    tick();
    wready = 0;
    // data read while the write waits for B
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1C008000; data_sram_size = 2'd2;
    #1;
    chk("w1_wvalid_bwait", {31'b0, wvalid}, 32'd0);
    chk("w1_data_ok_before_b", {31'b0, data_sram_data_ok}, 32'd0);
    chk("hz_addr_ok_bwait", {31'b0, data_sram_addr_ok}, 32'd0);
    tick();
    bvalid = 1;
    #1;
    chk("w1_data_ok_on_b", {31'b0, data_sram_data_ok}, 32'd1);
    chk("hz_addr_ok_b_cycle", {31'b0, data_sram_addr_ok}, 32'd0);
    tick();
    bvalid = 0; arready = 1;
    #1;
    chk("hz_addr_ok_after_b", {31'b0, data_sram_addr_ok}, 32'd1);
    push_data(1'b0, 32'h0000BEEF);
    tick();
    data_sram_req = 0;
    #1;
    chk("hz_arvalid", {31'b0, arvalid}, 32'd1);
    chk("hz_arid", {28'b0, arid}, 32'd1);
    tick();
    arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h0000BEEF;
    #1;
    chk("hz_data_ok", {31'b0, data_sram_data_ok}, 32'd1);
    tick();
    rvalid = 0;

    // ---- data write, AW and W accepted together ----
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1C00A000;
    data_sram_size = 2'd2; data_sram_wstrb = 4'hF; data_sram_wdata = 32'h12345678;
    awready = 1; wready = 1;
    #1;
    chk("w2_addr_ok", {31'b0, data_sram_addr_ok}, 32'd1);
    push_data(1'b1, 32'h0);
    tick();
    data_sram_req = 0; data_sram_wr = 0;
    #1;
    chk("w2_awvalid_c1", {31'b0, awvalid}, 32'd1);
    chk("w2_wvalid_c1", {31'b0, wvalid}, 32'd1);
    tick();
    awready = 0; wready = 0; bvalid = 1;
    #1;
    chk("w2_awvalid_c2", {31'b0, awvalid}, 32'd0);
    chk("w2_wvalid_c2", {31'b0, wvalid}, 32'd0);
    chk("w2_data_ok", {31'b0, data_sram_data_ok}, 32'd1);
    tick();
    bvalid = 0;

    // ---- stray rid is dropped, pending data read survives ----
    data_sram_req = 1; data_sram_addr = 32'h1C000100; data_sram_size = 2'd2; arready = 1;
    #1;
    chk("s1_addr_ok", {31'b0, data_sram_addr_ok}, 32'd1);
    push_data(1'b0, 32'h0BADF00D);
    tick();
    data_sram_req = 0;
    tick();
    arready = 0; rvalid = 1; rid = 4'd5; rdata = 32'hFFFFFFFF;
    #1;
    chk("s1_rid5_data_ok", {31'b0, data_sram_data_ok}, 32'd0);
    chk("s1_rid5_inst_ok", {31'b0, inst_sram_data_ok}, 32'd0);
    tick();
    rid = 4'd0;
    #1;
    chk("s1_rid0_nopend_inst_ok", {31'b0, inst_sram_data_ok}, 32'd0);
    tick();
    rid = 4'd1; rdata = 32'h0BADF00D;
    #1;
    chk("s1_rid1_data_ok", {31'b0, data_sram_data_ok}, 32'd1);
    tick();
    rvalid = 0;

    // ---- reset with a fetch outstanding ----
    inst_sram_req = 1; inst_sram_addr = 32'h1C000080; arready = 1;
    #1;
    chk("r1_inst_addr_ok", {31'b0, inst_sram_addr_ok}, 32'd1);
    tick();
    inst_sram_req = 0;
    #1;
    chk("r1_arvalid", {31'b0, arvalid}, 32'd1);
    tick();
    reset = 1;
    tick();
    reset = 0; rvalid = 1; rid = 4'd0; rdata = 32'hDEADBEEF;
    #1;
    chk("r1_inst_data_ok", {31'b0, inst_sram_data_ok}, 32'd0);
    chk("r1_data_data_ok", {31'b0, data_sram_data_ok}, 32'd0);
    chk("r1_arvalid_after", {31'b0, arvalid}, 32'd0);
    chk("r1_araddr_after", araddr, 32'd0);
    chk("r1_awaddr_after", awaddr, 32'd0);
    chk("r1_rready", {31'b0, rready}, 32'd1);
    tick();
    rvalid = 0;
    // a fresh fetch works after reset
    inst_sram_req = 1; inst_sram_addr = 32'h1C0000C0;
    #1;
    chk("r2_inst_addr_ok", {31'b0, inst_sram_addr_ok}, 32'd1);
    inst_q.push_back(32'h00C0FFEE);
    tick();
    inst_sram_req = 0;
    tick();
    arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h00C0FFEE;
    #1;
    chk("r2_inst_data_ok", {31'b0, inst_sram_data_ok}, 32'd1);
    tick();
    rvalid = 0;
    tick(); tick();

    chk("inst_queue_drained", inst_q.size(), 32'd0);
    chk("data_queue_drained", data_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
